// File: rtl/apb_slave_with_mem.sv
// rtl/apb_slave_with_mem.sv - APB slave fronting a 256 x 8 register memory
//
// Ports:
//   clk        rising-edge clock for all state and memory
//   reset      synchronous active-high reset (clears FSM and whole memory)
//   psel       slave select
//   penable    access phase qualifier
//   pwrite     1 = write, 0 = read
//   paddr      byte address into the 256-entry memory
//   pwdata     write data
//   prdata     read data, valid during read access, 0 otherwise
//   pready     transfer completes on the rising edge where high
//   id         static slave identifier
//   slave_id   id while pready is high, else 0
//   mem_ready  memory ready; low inserts APB wait states
//   mem_ce     memory chip enable
//   mem_wren   memory write enable
//   mem_rden   memory read enable
//   state      FSM state: IDLE=0, SETUP=1, ACCESS=2

module apb_slave_with_mem (
   input  logic       clk,
   input  logic       reset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   input  logic [1:0] id,
   output logic [1:0] slave_id,
   input  logic       mem_ready,
   output logic       mem_ce,
   output logic       mem_wren,
   output logic       mem_rden,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [7:0] mem [256];
   logic       setup_phase;
   logic       access_phase;
   logic       wr_commit;

   // Phase decode comes straight off the bus; the state register only
   // reports progress and never gates the data path.
   assign setup_phase  = psel & ~penable;
   assign access_phase = psel & penable;
   assign wr_commit    = access_phase & pwrite & mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = ST_IDLE;
      pready   = 1'b0;
      slave_id = 2'd0;
      prdata   = 8'd0;
      mem_ce   = psel;
      mem_wren = psel & pwrite;
      mem_rden = psel & ~pwrite;

      if (setup_phase) begin
         state_d = ST_SETUP;
      end else if (access_phase && !mem_ready) begin
         // Hold in ACCESS while the memory stretches the transfer.
         state_d = ST_ACCESS;
      end

      if (access_phase && mem_ready) begin
         pready   = 1'b1;
         slave_id = id;
      end

      if (access_phase && !pwrite) begin
         prdata = mem[paddr];
      end
   end

   assign state = state_q;

   // Reset wins over a simultaneous write, so a transfer caught by reset is
   // dropped rather than committed.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] <= 8'd0;
         end
      end else if (wr_commit) begin
         mem[paddr] <= pwdata;
      end
   end

endmodule

// File: tb/tb_apb_slave_with_mem.sv
// tb/tb_apb_slave_with_mem.sv - self-checking bench for apb_slave_with_mem

module tb_apb_slave_with_mem;

   logic       clk = 1'b0;
   logic       reset;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic [1:0] id;
   logic [1:0] slave_id;
   logic       mem_ready;
   logic       mem_ce;
   logic       mem_wren;
   logic       mem_rden;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   logic [7:0] model_mem [256];
   int         model_state;

   always #5 clk = ~clk;

   apb_slave_with_mem dut (
      .clk       (clk),
      .reset     (reset),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .id        (id),
      .slave_id  (slave_id),
      .mem_ready (mem_ready),
      .mem_ce    (mem_ce),
      .mem_wren  (mem_wren),
      .mem_rden  (mem_rden),
      .state     (state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: memory as a plain array updated by the bus rules, and the state
   // as the phase the bus was in at the last edge.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) model_mem[i] = 8'd0;
         model_state = 0;
      end else begin
         if (psel && penable && pwrite && mem_ready) model_mem[paddr] = pwdata;
         if (!psel)                 model_state = 0;
         else if (!penable)         model_state = 1;
         else if (!mem_ready)       model_state = 2;
         else                       model_state = 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         bit rd_acc;
         bit done;
         rd_acc = psel && penable && !pwrite;
         done   = psel && penable && mem_ready;
         check("prdata",   {24'd0, prdata},   rd_acc ? {24'd0, model_mem[paddr]} : 32'd0);
         check("pready",   {31'd0, pready},   {31'd0, done});
         check("slave_id", {30'd0, slave_id}, done ? {30'd0, id} : 32'd0);
         check("mem_ce",   {31'd0, mem_ce},   {31'd0, psel});
         check("mem_wren", {31'd0, mem_wren}, {31'd0, psel && pwrite});
         check("mem_rden", {31'd0, mem_rden}, {31'd0, psel && !pwrite});
         check("state",    {29'd0, state},    model_state);
      end
   end

   task automatic bus_idle();
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      check("idle_state", {29'd0, state}, 32'd0);
   endtask

   // One transfer: setup cycle, then access with `waits` wait states.
   // Leaves the bus in the completing access cycle so a caller can go
   // straight into another setup.
   task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input int waits, input logic [7:0] exp_rd);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; mem_ready = 1'b1;
      @(posedge clk); #1;
      penable = 1'b1; mem_ready = (waits == 0);
      for (int k = 0; k < waits; k++) begin
         @(negedge clk);
         check("wait_pready", {31'd0, pready}, 32'd0);
         check("wait_state", {29'd0, state}, (k == 0) ? 32'd1 : 32'd2);
         @(posedge clk); #1;
         mem_ready = (k == waits - 1);
      end
      @(negedge clk);
      check("done_pready", {31'd0, pready}, 32'd1);
      check("done_slave_id", {30'd0, slave_id}, 32'd1);
      check("done_state", {29'd0, state}, (waits == 0) ? 32'd1 : 32'd2);
      if (!wr) check("done_prdata", {24'd0, prdata}, {24'd0, exp_rd});
   endtask

   initial begin
      reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'd0; pwdata = 8'd0; id = 2'd1; mem_ready = 1'b1;
      @(posedge clk); #1;
      cmp_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_pready", {31'd0, pready}, 32'd0);
      check("rst_prdata", {24'd0, prdata}, 32'd0);
      check("rst_slave_id", {30'd0, slave_id}, 32'd0);
      check("rst_ce", {29'd0, mem_ce, mem_wren, mem_rden}, 32'd0);

      // zero-wait, 5-wait, 1-wait, 3-wait write then read-back
      xfer(1'b1, 8'd6, 8'd5, 0, 8'd0); bus_idle();
      xfer(1'b0, 8'd6, 8'd0, 0, 8'd5); bus_idle();
      xfer(1'b1, 8'd5, 8'd4, 5, 8'd0); bus_idle();
      xfer(1'b0, 8'd5, 8'd0, 5, 8'd4); bus_idle();
      xfer(1'b1, 8'd4, 8'd3, 1, 8'd0); bus_idle();
      xfer(1'b0, 8'd4, 8'd0, 1, 8'd3); bus_idle();
      xfer(1'b1, 8'd3, 8'd2, 3, 8'd0); bus_idle();
      xfer(1'b0, 8'd3, 8'd0, 3, 8'd2); bus_idle();

      // never-written address and the top address
      xfer(1'b0, 8'd200, 8'd0, 0, 8'd0); bus_idle();
      xfer(1'b1, 8'd255, 8'hA5, 2, 8'd0); bus_idle();
      xfer(1'b0, 8'd255, 8'd0, 0, 8'hA5); bus_idle();

      // back-to-back transfers with no idle cycle between them
      xfer(1'b1, 8'd10, 8'h11, 0, 8'd0);
      xfer(1'b1, 8'd11, 8'h22, 1, 8'd0);
      xfer(1'b0, 8'd10, 8'd0, 0, 8'h11);
      xfer(1'b0, 8'd11, 8'd0, 2, 8'h22);
      bus_idle();

      // abort: mem_ready held low, then psel dropped
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 8'd9;
      @(posedge clk); #1;
      penable = 1'b1; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      check("abort_state_hold", {29'd0, state}, 32'd2);
      bus_idle();
      xfer(1'b0, 8'd7, 8'd0, 0, 8'd0); bus_idle();

      // penable without psel must do nothing
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 8'd9; pwdata = 8'h77; mem_ready = 1'b1;
      @(negedge clk);
      check("nosel_pready", {31'd0, pready}, 32'd0);
      bus_idle();
      xfer(1'b0, 8'd9, 8'd0, 0, 8'd0); bus_idle();

      // reset in the middle of a completing write drops it and clears memory
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd8; pwdata = 8'hAA;
      @(posedge clk); #1;
      penable = 1'b1; mem_ready = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge clk);
      check("post_rst_state", {29'd0, state}, 32'd0);
      xfer(1'b0, 8'd8, 8'd0, 0, 8'd0); bus_idle();
      for (int a = 3; a <= 6; a++) begin
         xfer(1'b0, 8'(a), 8'd0, 0, 8'd0);
         bus_idle();
      end
      xfer(1'b0, 8'd255, 8'd0, 1, 8'd0); bus_idle();

      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
